// File: rtl/akaur014_ha_pkg.sv
// Shared pin map and counter width for the akaur014 half-adder tile.
package akaur014_ha_pkg;

  localparam int unsigned CNT_W = 4;

  localparam int unsigned A_BIT      = 0;
  localparam int unsigned B_BIT      = 1;
  localparam int unsigned SUM_BIT    = 0;
  localparam int unsigned CARRY_BIT  = 1;
  localparam int unsigned SUMQ_BIT   = 2;
  localparam int unsigned CARRYQ_BIT = 3;
  localparam int unsigned CNT_LSB    = 4;

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder.
module half_adder_cell (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/akaur014_half_adder.sv
// Tiny Tapeout tile: half adder on ui_in[1:0], registered copies and a wrapping carry counter.
module akaur014_half_adder
  import akaur014_ha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             sum;
  logic             carry;
  logic             sum_d, sum_q;
  logic             carry_d, carry_q;
  logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

  half_adder_cell u_cell (
    .a_i     (ui_in[A_BIT]),
    .b_i     (ui_in[B_BIT]),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    if (ena) begin
      sum_d       = sum;
      carry_d     = carry;
      carry_cnt_d = carry_cnt_q + {{(CNT_W-1){1'b0}}, carry};
    end
  end

  // rst_n keeps the harness name but is active-high here; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  always_comb begin
    uo_out                       = '0;
    uo_out[SUM_BIT]              = sum;
    uo_out[CARRY_BIT]            = carry;
    uo_out[SUMQ_BIT]             = sum_q;
    uo_out[CARRYQ_BIT]           = carry_q;
    uo_out[CNT_LSB +: CNT_W]     = carry_cnt_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_inputs;
  assign unused_inputs = ^{ui_in[7:2], uio_in};

endmodule

// File: tb/tb_akaur014_half_adder.sv
// Directed self-checking bench for the akaur014 half-adder tile.
module tb_akaur014_half_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests;
  int n_fail;

  akaur014_half_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_in  [4];
  logic [1:0] tt_exp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tt_in[0] = 2'b00; tt_exp[0] = 2'b00;
    tt_in[1] = 2'b01; tt_exp[1] = 2'b01;
    tt_in[2] = 2'b10; tt_exp[2] = 2'b01;
    tt_in[3] = 2'b11; tt_exp[3] = 2'b10;

    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h03;
    uio_in = 8'h00;

    // Reset holds registers at zero; comb bits follow inputs.
    tick();
    tick();
    check("reset_uo", uo_out, 8'h02);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);

    // Truth table: comb at once, registered one cycle later.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ui_in = {6'b101100, tt_in[i]};
      #1;
      check("tt_comb", {6'b0, uo_out[1:0]}, {6'b0, tt_exp[i]});
      tick();
      check("tt_reg", {6'b0, uo_out[3:2]}, {6'b0, tt_exp[i]});
    end
    check("tt_cnt", {4'b0, uo_out[7:4]}, 8'h01);

    // Counter wraps after 16 carries.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    ui_in = 8'h03;
    for (int i = 0; i < 17; i++) tick();
    check("wrap_cnt", {4'b0, uo_out[7:4]}, 8'h01);
    check("wrap_uo", uo_out, 8'h1A);

    // Enable gating from cnt=3.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("gate_pre", uo_out, 8'h3A);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_hold", {2'b0, uo_out[7:2]}, 8'h0E);
    end
    check("gate_comb", {6'b0, uo_out[1:0]}, 8'h02);

    // Mid-run reset from cnt=9 beats ena.
    ena   = 1'b1;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("midrst_pre", uo_out, 8'h9A);
    rst_n = 1'b1;
    tick();
    check("midrst_hi", {2'b0, uo_out[7:2]}, 8'h00);
    check("midrst_uo", uo_out, 8'h02);
    rst_n = 1'b0;

    // Unused inputs toggled randomly have no effect.
    for (int i = 0; i < 8; i++) begin
      ui_in  = {6'($urandom), 2'b01};
      uio_in = 8'($urandom);
      #1;
      check("dc_comb", {6'b0, uo_out[1:0]}, 8'h01);
      check("dc_uio_out", uio_out, 8'h00);
      check("dc_uio_oe", uio_oe, 8'h00);
      tick();
      check("dc_uo", uo_out, 8'h05);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
